// File: rtl/exe_if.sv
// EXE stage bus: ID/EXE operands, forwarding selects, EXE/MEM outputs.
// master drives operands and controls, slave is the execute stage.
interface exe_if #(
  parameter int DW = 32,
  parameter int RW = 4
);
  logic [1:0]    sel_src1;
  logic [1:0]    sel_src2;
  logic [DW-1:0] val_rn_id;
  logic [DW-1:0] val_rm_id;
  logic [DW-1:0] alu_res_mem;
  logic [DW-1:0] wb_value;
  logic [3:0]    exe_cmd;
  logic          s_in;
  logic          imm;
  logic [11:0]   shift_operand;
  logic [23:0]   signed_imm_24;
  logic [DW-1:0] pc_in;
  logic          mem_r_en_in;
  logic          mem_w_en_in;
  logic          wb_en_in;
  logic [RW-1:0] dest_in;
  logic          freeze;

  logic [DW-1:0] branch_addr;
  logic [3:0]    status;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] val_rm_out;
  logic [RW-1:0] dest;
  logic          wb_en;
  logic          mem_r_en;
  logic          mem_w_en;

  modport master (
    output sel_src1, sel_src2,
    output val_rn_id, val_rm_id,
    output alu_res_mem, wb_value,
    output exe_cmd, s_in, imm,
    output shift_operand, signed_imm_24,
    output pc_in, mem_r_en_in,
    output mem_w_en_in, wb_en_in,
    output dest_in, freeze,
    input  branch_addr, status,
    input  alu_res, val_rm_out,
    input  dest, wb_en,
    input  mem_r_en, mem_w_en
  );

  modport slave (
    input  sel_src1, sel_src2,
    input  val_rn_id, val_rm_id,
    input  alu_res_mem, wb_value,
    input  exe_cmd, s_in, imm,
    input  shift_operand, signed_imm_24,
    input  pc_in, mem_r_en_in,
    input  mem_w_en_in, wb_en_in,
    input  dest_in, freeze,
    output branch_addr, status,
    output alu_res, val_rm_out,
    output dest, wb_en,
    output mem_r_en, mem_w_en
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, shifter operand, ALU,
// NZCV register, branch adder and EXE/MEM pipeline register.
module exe_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input logic clk,
  input logic rst,
  exe_if.slave bus
);
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DW-1:0]   op1;
  logic [DW-1:0]   rm_f;
  logic [DW-1:0]   val2;
  logic [DW-1:0]   imm8;
  logic [2*DW-1:0] rot_w;
  logic [4:0]      rot_amt;
  logic [4:0]      sh_amt;
  logic [DW:0]     sum;
  logic [DW-1:0]   res;
  logic            cin;
  logic            n_d, z_d, c_d, v_d;
  logic            nz_upd;

  logic [3:0]      status_q;
  logic [DW-1:0]   alu_res_q;
  logic [DW-1:0]   val_rm_q;
  logic [RW-1:0]   dest_q;
  logic            wb_en_q;
  logic            mem_r_q;
  logic            mem_w_q;

  assign cin = status_q[1];

  // Forwarding muxes; code 11 falls back to the ID/EXE value
  always_comb begin
    op1  = bus.val_rn_id;
    rm_f = bus.val_rm_id;
    unique case (1'b1)
      (bus.sel_src1 == 2'b01): op1 = bus.alu_res_mem;
      (bus.sel_src1 == 2'b10): op1 = bus.wb_value;
      default:                 op1 = bus.val_rn_id;
    endcase
    unique case (1'b1)
      (bus.sel_src2 == 2'b01): rm_f = bus.alu_res_mem;
      (bus.sel_src2 == 2'b10): rm_f = bus.wb_value;
      default:                 rm_f = bus.val_rm_id;
    endcase
  end

  // Shifter operand; memory offsets beat the immediate form
  always_comb begin
    imm8    = {{(DW-8){1'b0}}, bus.shift_operand[7:0]};
    rot_amt = {bus.shift_operand[11:8], 1'b0};
    sh_amt  = bus.shift_operand[11:7];
    rot_w   = '0;
    val2    = rm_f;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {{(DW-12){1'b0}}, bus.shift_operand};
    end else if (bus.imm) begin
      rot_w = {imm8, imm8} >> rot_amt;
      val2  = rot_w[DW-1:0];
    end else begin
      unique case (bus.shift_operand[6:5])
        2'b00: val2 = rm_f << sh_amt;
        2'b01: val2 = rm_f >> sh_amt;
        2'b10: val2 = $signed(rm_f) >>> sh_amt;
        default: begin
          rot_w = {rm_f, rm_f} >> sh_amt;
          val2  = rot_w[DW-1:0];
        end
      endcase
    end
  end

  // ALU and next NZCV; unknown commands keep every flag
  always_comb begin
    sum    = '0;
    res    = '0;
    nz_upd = 1'b1;
    c_d    = status_q[1];
    v_d    = status_q[0];
    case (bus.exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2}
            + {{DW{1'b0}}, cin & (bus.exe_cmd == CMD_ADC)};
        res = sum[DW-1:0];
        c_d = sum[DW];
        v_d = (op1[DW-1] == val2[DW-1])
            && (res[DW-1] != op1[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, op1} + {1'b0, ~val2}
            + {{DW{1'b0}}, (bus.exe_cmd == CMD_SUB) | cin};
        res = sum[DW-1:0];
        c_d = sum[DW];
        v_d = (op1[DW-1] != val2[DW-1])
            && (res[DW-1] != op1[DW-1]);
      end
      default: nz_upd = 1'b0;
    endcase
    n_d = nz_upd ? res[DW-1] : status_q[3];
    z_d = nz_upd ? (res == '0) : status_q[2];
  end

  // NZCV and EXE/MEM register; freeze holds everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q  <= '0;
      alu_res_q <= '0;
      val_rm_q  <= '0;
      dest_q    <= '0;
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
    end else if (!bus.freeze) begin
      if (bus.s_in) status_q <= {n_d, z_d, c_d, v_d};
      alu_res_q <= res;
      val_rm_q  <= rm_f;
      dest_q    <= bus.dest_in;
      wb_en_q   <= bus.wb_en_in;
      mem_r_q   <= bus.mem_r_en_in;
      mem_w_q   <= bus.mem_w_en_in;
    end
  end

  assign bus.branch_addr = bus.pc_in
    + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
  assign bus.status      = status_q;
  assign bus.alu_res     = alu_res_q;
  assign bus.val_rm_out  = val_rm_q;
  assign bus.dest        = dest_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.mem_r_en    = mem_r_q;
  assign bus.mem_w_en    = mem_w_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: vector table plus freeze/reset
// and branch-target sequences.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  exe_if #(.DW(32), .RW(4)) bus ();
  exe_stage #(.DW(32), .RW(4)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001;
  localparam logic [3:0] ADD = 4'b0010, ADC = 4'b0011;
  localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101;
  localparam logic [3:0] AND = 4'b0110, ORR = 4'b0111;
  localparam logic [3:0] EOR = 4'b1000, BAD = 4'b0000;

  typedef struct packed {
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] am;
    logic [31:0] wv;
    logic [3:0]  cmd;
    logic        s;
    logic        im;
    logic [11:0] so;
    logic        rd;
    logic        wr;
    logic [31:0] eres;
    logic [3:0]  est;
    logic [31:0] erm;
  } vec_t;

  localparam int NV = 22;
  vec_t v [NV];

  function automatic vec_t mk(
    input logic [1:0] s1, input logic [1:0] s2,
    input logic [31:0] rn, input logic [31:0] rm,
    input logic [31:0] am, input logic [31:0] wv,
    input logic [3:0] cmd, input logic s,
    input logic im, input logic [11:0] so,
    input logic rd, input logic wr,
    input logic [31:0] eres, input logic [3:0] est,
    input logic [31:0] erm);
    vec_t t;
    t.s1 = s1; t.s2 = s2; t.rn = rn; t.rm = rm;
    t.am = am; t.wv = wv; t.cmd = cmd; t.s = s;
    t.im = im; t.so = so; t.rd = rd; t.wr = wr;
    t.eres = eres; t.est = est; t.erm = erm;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " alu_res"}, bus.alu_res, 32'h0);
    chk({tag, " status"}, {28'h0, bus.status}, 32'h0);
    chk({tag, " val_rm"}, bus.val_rm_out, 32'h0);
    chk({tag, " dest"}, {28'h0, bus.dest}, 32'h0);
    chk({tag, " ctl"},
        {29'h0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'h0);
  endtask

  task automatic drive(input vec_t t, input logic [3:0] d,
                       input logic w);
    bus.sel_src1      = t.s1;
    bus.sel_src2      = t.s2;
    bus.val_rn_id     = t.rn;
    bus.val_rm_id     = t.rm;
    bus.alu_res_mem   = t.am;
    bus.wb_value      = t.wv;
    bus.exe_cmd       = t.cmd;
    bus.s_in          = t.s;
    bus.imm           = t.im;
    bus.shift_operand = t.so;
    bus.mem_r_en_in   = t.rd;
    bus.mem_w_en_in   = t.wr;
    bus.dest_in       = d;
    bus.wb_en_in      = w;
  endtask

  logic [31:0] pcs [4];
  logic [23:0] offs [4];
  logic [31:0] bexp [4];

  initial begin
    v[0]  = mk(1,0,1,0,5,9,ADD,0,1,12'h001,0,0,
               32'h6,4'b0000,0);
    v[1]  = mk(2,0,1,0,5,9,ADD,0,1,12'h001,0,0,
               32'hA,4'b0000,0);
    v[2]  = mk(3,0,1,0,5,9,ADD,0,1,12'h001,0,0,
               32'h2,4'b0000,0);
    v[3]  = mk(0,0,32'h7FFFFFFF,0,0,0,ADD,1,1,12'h001,0,0,
               32'h80000000,4'b1001,0);
    v[4]  = mk(0,0,5,0,0,0,SUB,1,1,12'h005,0,0,
               32'h0,4'b0110,0);
    v[5]  = mk(0,0,32'hFFFFFFFF,0,0,0,ADD,1,1,12'h001,0,0,
               32'h0,4'b0110,0);
    v[6]  = mk(0,0,0,0,0,0,ADC,1,1,12'h000,0,0,
               32'h1,4'b0000,0);
    v[7]  = mk(0,0,3,0,0,0,SBC,1,1,12'h001,0,0,
               32'h1,4'b0010,0);
    v[8]  = mk(0,0,0,0,0,0,MOV,0,1,12'h4FF,0,0,
               32'hFF000000,4'b0010,0);
    v[9]  = mk(0,0,0,32'h80000000,0,0,MOV,1,0,12'h240,0,0,
               32'hF8000000,4'b1010,32'h80000000);
    v[10] = mk(0,0,0,32'hAB,0,0,MOV,0,0,12'h460,0,0,
               32'hAB000000,4'b1010,32'hAB);
    v[11] = mk(0,1,0,0,32'h1234,0,ADD,0,0,12'hFFF,0,1,
               32'hFFF,4'b1010,32'h1234);
    v[12] = mk(0,0,0,0,0,0,MVN,1,1,12'h000,0,0,
               32'hFFFFFFFF,4'b1010,0);
    v[13] = mk(0,0,32'hF0F0,32'hFF00,0,0,AND,1,0,12'h000,0,0,
               32'hF000,4'b0010,32'hFF00);
    v[14] = mk(0,0,32'hF0F0,32'hFF00,0,0,ORR,0,0,12'h000,0,0,
               32'hFFF0,4'b0010,32'hFF00);
    v[15] = mk(0,0,32'hF0F0,32'hFF00,0,0,EOR,0,0,12'h000,0,0,
               32'h0FF0,4'b0010,32'hFF00);
    v[16] = mk(0,0,5,0,0,0,BAD,1,1,12'h001,0,0,
               32'h0,4'b0010,0);
    v[17] = mk(0,0,0,32'h80000000,0,0,MOV,0,0,12'hFA0,0,0,
               32'h1,4'b0010,32'h80000000);
    v[18] = mk(0,2,0,0,0,1,MOV,0,0,12'h200,0,0,
               32'h10,4'b0010,32'h1);
    v[19] = mk(0,0,0,0,0,0,SUB,1,1,12'h001,0,0,
               32'hFFFFFFFF,4'b1000,0);
    v[20] = mk(0,0,0,32'h12345678,0,0,MOV,0,0,12'h060,0,0,
               32'h12345678,4'b1000,32'h12345678);
    v[21] = mk(0,0,32'h100,0,0,0,ADD,0,1,12'h4FF,1,0,
               32'h5FF,4'b1000,0);

    pcs[0] = 32'h100;      offs[0] = 24'hFFFFFE;
    bexp[0] = 32'hF8;
    pcs[1] = 32'h100;      offs[1] = 24'h000003;
    bexp[1] = 32'h10C;
    pcs[2] = 32'hFFFFFFFC; offs[2] = 24'h000001;
    bexp[2] = 32'h0;
    pcs[3] = 32'h0;        offs[3] = 24'h800000;
    bexp[3] = 32'hFE000000;

    rst_n = 1'b0;
    bus.freeze = 1'b0;
    bus.pc_in = '0;
    bus.signed_imm_24 = '0;
    drive(v[0], 4'h0, 1'b0);
    #3;
    chk_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(v[i], 4'(i), i[0]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d alu_res", i), bus.alu_res, v[i].eres);
      chk($sformatf("v%0d status", i),
          {28'h0, bus.status}, {28'h0, v[i].est});
      chk($sformatf("v%0d val_rm", i), bus.val_rm_out, v[i].erm);
      chk($sformatf("v%0d dest/wb", i),
          {27'h0, bus.dest, bus.wb_en}, {27'h0, 4'(i), i[0]});
      chk($sformatf("v%0d mem_en", i),
          {30'h0, bus.mem_r_en, bus.mem_w_en},
          {30'h0, v[i].rd, v[i].wr});
    end

    drive(mk(0,0,32'hFFFFFFF0,0,0,0,ADD,1,1,12'h020,0,0,
             0,0,0), 4'h5, 1'b1);
    @(posedge clk);
    #1;
    chk("frz load res", bus.alu_res, 32'h10);
    chk("frz load st", {28'h0, bus.status}, 32'h2);
    bus.freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mk(0,1,32'(k * 7 + 1),32'h55,32'h77,0,SUB,1,1,
               12'h001,0,1,0,0,0), 4'h9, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("frz%0d res", k), bus.alu_res, 32'h10);
      chk($sformatf("frz%0d st", k),
          {28'h0, bus.status}, 32'h2);
      chk($sformatf("frz%0d rm", k), bus.val_rm_out, 32'h0);
      chk($sformatf("frz%0d dst/ctl", k),
          {25'h0, bus.dest, bus.wb_en, bus.mem_r_en,
           bus.mem_w_en}, {25'h0, 4'h5, 3'b100});
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst in freeze");
    @(posedge clk);
    #1;
    chk_zero("rst held");
    @(negedge clk);
    rst_n = 1'b1;
    bus.freeze = 1'b0;

    for (int b = 0; b < 4; b++) begin
      bus.pc_in = pcs[b];
      bus.signed_imm_24 = offs[b];
      #1;
      chk($sformatf("branch%0d", b), bus.branch_addr, bexp[b]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
